// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - handshake and operand/result bundle for div_unit
//   start     master->slave  begin a division
//   dividend  master->slave  signed dividend
//   divisor   master->slave  signed divisor
//   hi        slave->master  remainder
//   lo        slave->master  quotient
//   busy      slave->master  division in progress
//   done      slave->master  one-cycle result/div_zero valid pulse
//   div_zero  slave->master  divisor was zero (valid with done)
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider (quotient on lo, remainder on hi)
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high
//   bus    slave modport of div_unit_if: start/dividend/divisor in,
//          hi/lo/busy/done/div_zero out
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divs_q, divs_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    // Partial remainder shifted left with the next dividend bit; one bit wider
    // than the operands so the trial subtraction's borrow is visible.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divs_d     = divs_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, divs_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_d  = CALC;
                        sign_a_d = bus.dividend[WIDTH-1];
                        sign_b_d = bus.divisor[WIDTH-1];
                        // Negating the most negative value yields the same bit
                        // pattern, which read unsigned is exactly its magnitude.
                        quo_d    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                        divs_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                        rem_d    = '0;
                        cnt_d    = CW'(WIDTH - 1);
                    end else begin
                        state_d    = DONE;
                        div_zero_d = 1'b1;
                    end
                end
            end
            CALC: begin
                // The dividend register doubles as the quotient register: each
                // cycle its MSB moves into the remainder and a quotient bit enters at bit 0.
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                lo_d    = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                hi_d    = sign_a_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                div_zero_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divs_q     <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divs_q     <= divs_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q == CALC) || (state_q == FIX);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; operands are scrambled so latching is exercised.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
        sb.push_back(e);
        @(posedge clock);
        #1;
        cyc          = 0;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    // Wait for done (bounded); optionally re-pulse start with 1/1 at cycle gl.
    task automatic finish_op(input int gl);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            step();
            if (cyc == gl) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd1;
                bus.divisor  = 32'd1;
            end
            @(negedge clock);
            if (cyc == 1 && sb.size() > 0) begin
                chk("busy_cycle1", {31'd0, bus.busy}, {31'd0, sb[0].lat > 1});
            end
            if (bus.done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.lat));
                chk("hi", bus.hi, e.hi);
                chk("lo", bus.lo, e.lo);
                chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            step();
            @(negedge clock);
            chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
            chk("div_zero_clear", {31'd0, bus.div_zero}, 32'd0);
        end
    endtask

    initial begin
        logic signed [31:0] ra, rb;
        int dones;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);

        launch(32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34);                      finish_op(-1);
        launch(-32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);      finish_op(-1);
        launch(32'd7, -32'sd2, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);      finish_op(-1);
        launch(32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34); finish_op(-1);
        launch(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 34); finish_op(-1);
        launch(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);                   finish_op(-1);
        launch(32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 1);                      finish_op(-1);
        launch(32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 34);                      finish_op(5);

        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 5000);
            if (k == 1) rb = -rb;
            launch(ra, rb, ra % rb, ra / rb, 1'b0, 34);
            finish_op(-1);
        end

        // Reset during CALC aborts with no done pulse.
        @(posedge clock);
        #1;
        cyc = 0; bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd3;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        dones = 0;
        repeat (40) begin
            step();
            @(negedge clock);
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        launch(32'd50, 32'd3, 32'd2, 32'd16, 1'b0, 34); finish_op(-1);

        // Reset asserted together with start: reset wins.
        @(posedge clock);
        #1;
        reset = 1'b1; bus.start = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
        @(posedge clock);
        #1;
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clock);
        chk("rst_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_start_lo", bus.lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
